ram_sweep_ctrl: RTL and testbench

RAM-side controller that drives the 256x8 single-port RAM directly: address, write data, wren and rden.
- After reset it fills the RAM with a deterministic pattern in one burst of 256 writes.
- It then reads the RAM back continuously, one address per display period, so the RAM output feeds the seven-segment display path.
- A one-cycle touch-key pulse pauses and resumes the read sweep.

---
 rtl/ram_sweep_pkg.sv | 23 ++
 rtl/ram_sweep_ctrl_if.sv | 20 ++
 rtl/ram_sweep_ctrl_period_tick.sv | 36 +++
 rtl/ram_sweep_ctrl.sv | 98 +++++++++
 tb/tb_ram_sweep_ctrl.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/ram_sweep_pkg.sv
// Shared types and helpers for the RAM sweep controller.
//   state_t   : controller FSM states (2-bit encoding)
//   ADDR_MAX  : last RAM address for the default 8-bit address width
//   cnt_width : bit width of a counter that must hold 0..period-1
package ram_sweep_pkg;

  typedef enum logic [1:0] {
    INIT  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    PAUSE = 2'd3
  } state_t;

  localparam int unsigned DEF_ADDR_W = 8;
  localparam int unsigned DEF_DATA_W = 8;
  localparam int unsigned ADDR_MAX   = (1 << DEF_ADDR_W) - 1;

  // Never below one bit so a degenerate period still yields a legal vector.
  function automatic int unsigned cnt_width(input int unsigned period);
    return (period < 2) ? 1 : $clog2(period);
  endfunction

endpackage

// File: rtl/ram_sweep_ctrl_if.sv
// RAM-side bus of the sweep controller.
//   wren    : RAM write enable
//   rden    : RAM read enable
//   data_in : RAM write data
//   addr    : RAM address
// master drives the RAM, slave observes it (RAM model or monitor).
interface ram_sweep_ctrl_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8
);

  logic              wren;
  logic              rden;
  logic [DATA_W-1:0] data_in;
  logic [ADDR_W-1:0] addr;

  modport master (output wren, rden, data_in, addr);
  modport slave  (input  wren, rden, data_in, addr);

endinterface

// File: rtl/ram_sweep_ctrl_period_tick.sv
// Read-period counter: counts 0..READ_PERIOD-1 while enabled and wraps.
//   sys_clk, rst_n : clock, asynchronous active-low reset
//   en             : count enable; the count holds when low
//   clr            : synchronous clear, wins over en
//   tick           : high during the terminal-count cycle (en must be high)
module period_tick
  import ram_sweep_pkg::*;
#(
  parameter int unsigned READ_PERIOD = 10_000_000
) (
  input  logic sys_clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int unsigned     CNT_W    = cnt_width(READ_PERIOD);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(READ_PERIOD - 1);

  logic [CNT_W-1:0] cnt;

  // Decoded from the count so the address step lands on the same edge as the wrap.
  assign tick = en && (cnt == CNT_LAST);

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick ? '0 : cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/ram_sweep_ctrl.sv
// Fills a single-port RAM with addr ^ PATTERN_XOR after reset, then sweeps
// reads one address per READ_PERIOD cycles; key_flag toggles a pause.
//   sys_clk, rst_n : clock, asynchronous active-low reset
//   key_flag       : one-cycle touch-key pulse
//   ram            : RAM bus (wren, rden, data_in, addr), all registered
//   paused         : read sweep frozen
//   fill_done      : set from the first read cycle until reset
module ram_sweep_ctrl
  import ram_sweep_pkg::*;
#(
  parameter int unsigned       ADDR_W      = DEF_ADDR_W,
  parameter int unsigned       DATA_W      = DEF_DATA_W,
  parameter int unsigned       READ_PERIOD = 10_000_000,
  parameter logic [DATA_W-1:0] PATTERN_XOR = DATA_W'(8'h00)
) (
  input  logic                  sys_clk,
  input  logic                  rst_n,
  input  logic                  key_flag,
  ram_sweep_ctrl_if.master      ram,
  output logic                  paused,
  output logic                  fill_done
);

  localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

  state_t            state;
  logic              tick;
  logic              cnt_en_c;
  logic              cnt_clr_c;
  logic [ADDR_W-1:0] addr_inc_c;

  // Count only while sweeping; hold through PAUSE, restart for each fill.
  assign cnt_en_c   = (state == READ);
  assign cnt_clr_c  = (state == INIT) || (state == WRITE);
  assign addr_inc_c = ram.addr + ADDR_W'(1);

  period_tick #(
    .READ_PERIOD (READ_PERIOD)
  ) u_period_tick (
    .sys_clk (sys_clk),
    .rst_n   (rst_n),
    .en      (cnt_en_c),
    .clr     (cnt_clr_c),
    .tick    (tick)
  );

  // Controller FSM with registered RAM-side and status outputs.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= INIT;
      ram.wren    <= 1'b0;
      ram.rden    <= 1'b0;
      ram.addr    <= '0;
      ram.data_in <= '0;
      paused      <= 1'b0;
      fill_done   <= 1'b0;
    end else begin
      unique case (state)
        INIT: begin
          state       <= WRITE;
          ram.wren    <= 1'b1;
          ram.addr    <= '0;
          ram.data_in <= PATTERN_XOR;
        end
        WRITE: begin
          if (ram.addr == ADDR_LAST) begin
            // data_in keeps the last written word through the read sweep.
            state     <= READ;
            ram.wren  <= 1'b0;
            ram.rden  <= 1'b1;
            ram.addr  <= '0;
            fill_done <= 1'b1;
          end else begin
            ram.addr    <= addr_inc_c;
            ram.data_in <= DATA_W'(addr_inc_c) ^ PATTERN_XOR;
          end
        end
        READ: begin
          // A key on a terminal-count cycle still takes the address step.
          if (tick) begin
            ram.addr <= addr_inc_c;
          end
          if (key_flag) begin
            state  <= PAUSE;
            paused <= 1'b1;
          end
        end
        PAUSE: begin
          if (key_flag) begin
            state  <= READ;
            paused <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_sweep_ctrl.sv
// Self-checking bench for ram_sweep_ctrl (READ_PERIOD=4, PATTERN_XOR=8'hA5).
// A cycle-count model predicts every output from elapsed cycles since reset
// release, the number of unpaused read cycles and the key-toggled pause flag.
module tb_ram_sweep_ctrl;

  localparam int unsigned P  = 4;
  localparam logic [7:0]  PX = 8'hA5;

  logic sys_clk = 1'b0;
  logic rst_n;
  logic key_flag;
  logic paused;
  logic fill_done;

  ram_sweep_ctrl_if #(.ADDR_W(8), .DATA_W(8)) ram_if ();

  ram_sweep_ctrl #(
    .ADDR_W      (8),
    .DATA_W      (8),
    .READ_PERIOD (P),
    .PATTERN_XOR (PX)
  ) dut (
    .sys_clk   (sys_clk),
    .rst_n     (rst_n),
    .key_flag  (key_flag),
    .ram       (ram_if),
    .paused    (paused),
    .fill_done (fill_done)
  );

  always #5 sys_clk = ~sys_clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: k = edges since release (saturates once reading), act_rd = read
  // cycles spent unpaused, m_paused = pause flag toggled by keys while reading.
  int k;
  int act_rd;
  bit m_paused;

  always @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      k        = 0;
      act_rd   = 0;
      m_paused = 1'b0;
    end else begin
      if (k >= 257) begin
        if (!m_paused) act_rd++;
        if (key_flag) m_paused = !m_paused;
      end
      if (k < 257) k++;
    end
  end

  function automatic logic [19:0] expected();
    logic [7:0] a;
    if (k == 0) return 20'h0;
    if (k <= 256) begin
      a = 8'(k - 1);
      return {1'b1, 1'b0, a, a ^ PX, 1'b0, 1'b0};
    end
    a = 8'((act_rd / P) % 256);
    return {1'b0, 1'b1, a, 8'hFF ^ PX, m_paused, 1'b1};
  endfunction

  function automatic logic [19:0] actual();
    return {ram_if.wren, ram_if.rden, ram_if.addr, ram_if.data_in, paused, fill_done};
  endfunction

  // Every-cycle comparison against the model.
  always @(negedge sys_clk) begin
    check("cycle", 32'(actual()), 32'(expected()));
  end

  task automatic wait_addr(input logic [7:0] a, input logic want_wren, input int limit);
    for (int i = 0; i < limit; i++) begin
      @(negedge sys_clk);
      if (ram_if.addr == a && ram_if.wren == want_wren && !paused) return;
    end
    n_tests++;
    n_fail++;
    $display("FAIL wait_addr: addr %0h not reached within %0d cycles, got %0h", a, limit, ram_if.addr);
  endtask

  task automatic pulse_key();
    key_flag = 1'b1;
    @(negedge sys_clk);
    key_flag = 1'b0;
  endtask

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n    = 1'b0;
    key_flag = 1'b0;
    repeat (5) @(posedge sys_clk);
    #1 rst_n = 1'b1;

    // INIT cycle, then first write word.
    @(negedge sys_clk);
    check("init_quiet", 32'(actual()), 32'h0);
    @(negedge sys_clk);
    check("first_write", 32'(actual()), 32'({1'b1, 1'b0, 8'h00, 8'hA5, 1'b0, 1'b0}));

    // Key during fill is ignored.
    wait_addr(8'h10, 1'b1, 300);
    pulse_key();
    check("fill_key_paused", 32'(paused), 32'(0));
    check("fill_key_wren", 32'(ram_if.wren), 32'(1));

    wait_addr(8'hFF, 1'b1, 300);
    check("last_write_data", 32'(ram_if.data_in), 32'h5A);
    @(negedge sys_clk);
    check("first_read", 32'(actual()), 32'({1'b0, 1'b1, 8'h00, 8'h5A, 1'b0, 1'b1}));

    // Pause at count 1 of addr 3, hold 20 cycles, resume.
    wait_addr(8'h03, 1'b0, 100);
    @(negedge sys_clk);
    pulse_key();
    check("pause_on", 32'({paused, ram_if.addr}), 32'({1'b1, 8'h03}));
    repeat (19) begin
      @(negedge sys_clk);
      check("pause_hold", 32'({paused, ram_if.addr}), 32'({1'b1, 8'h03}));
    end
    pulse_key();
    check("resume", 32'({paused, ram_if.addr}), 32'({1'b0, 8'h03}));
    @(negedge sys_clk);
    check("resume_dwell", 32'(ram_if.addr), 32'h03);
    @(negedge sys_clk);
    check("resume_step", 32'(ram_if.addr), 32'h04);

    // Key on the terminal count of addr 7.
    wait_addr(8'h07, 1'b0, 100);
    repeat (3) @(negedge sys_clk);
    pulse_key();
    check("key_on_tick", 32'({paused, ram_if.addr}), 32'({1'b1, 8'h08}));
    pulse_key();
    check("key_on_tick_resume", 32'(paused), 32'(0));

    // Wrap FF -> 00 after exactly P cycles.
    wait_addr(8'hFF, 1'b0, 1200);
    repeat (3) begin
      @(negedge sys_clk);
      check("wrap_hold", 32'(ram_if.addr), 32'hFF);
    end
    @(negedge sys_clk);
    check("wrap_zero", 32'(ram_if.addr), 32'h00);

    // Asynchronous reset between edges at addr 0x42.
    wait_addr(8'h42, 1'b0, 400);
    #2 rst_n = 1'b0;
    #1 check("async_reset", 32'(actual()), 32'h0);
    repeat (2) @(posedge sys_clk);
    #1 rst_n = 1'b1;
    wait_addr(8'hFF, 1'b1, 400);
    check("refill_last", 32'(ram_if.data_in), 32'h5A);
    @(negedge sys_clk);
    check("refill_read", 32'(actual()), 32'({1'b0, 1'b1, 8'h00, 8'h5A, 1'b0, 1'b1}));

    // Random key traffic against the model.
    repeat (2000) begin
      @(negedge sys_clk);
      key_flag = ($urandom_range(0, 15) == 0);
    end
    @(negedge sys_clk);
    key_flag = 1'b0;
    @(negedge sys_clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
